// File: rtl/mem_access_ctrl.sv
// Two-phase half-word sequencer between the MEM stage and a 16-bit asynchronous SRAM.
// Each 32-bit access runs LO then HI for WAIT_CYCLES clocks each, then pulses ready.
module mem_access_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        freeze,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_o,
   input  logic [15:0] sram_dq_i,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   localparam int unsigned CW = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic        op_wr;
   logic [16:0] word;
   logic [31:0] wbuf;

   logic        req;
   logic        phase_end;
   logic [16:0] req_word;
   logic        eff_wr;
   logic [16:0] eff_word;
   logic [31:0] eff_wdata;

   logic [31:0] rdata_nxt;
   logic        ready_nxt;
   logic [17:0] sram_addr_nxt;
   logic [15:0] sram_dq_o_nxt;
   logic        sram_dq_oe_nxt;
   logic        sram_we_n_nxt;

   assign req       = mem_r_en | mem_w_en;
   assign req_word  = 17'((addr - ADDR_BASE) >> 2);
   assign phase_end = (cnt == CNT_LAST);
   assign freeze    = req & ~ready;

   // SRAM pins are registered from the next state, so the entering edge must use the
   // live request fields while IDLE and the latched copy afterwards.
   assign eff_wr    = (state == IDLE) ? mem_w_en : op_wr;
   assign eff_word  = (state == IDLE) ? req_word : word;
   assign eff_wdata = (state == IDLE) ? wdata    : wbuf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         op_wr      <= 1'b0;
         word       <= '0;
         wbuf       <= '0;
         rdata      <= '0;
         ready      <= 1'b0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_we_n  <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         if (state == IDLE && req) begin
            op_wr <= mem_w_en;
            word  <= req_word;
            wbuf  <= wdata;
         end
         rdata      <= rdata_nxt;
         ready      <= ready_nxt;
         sram_addr  <= sram_addr_nxt;
         sram_dq_o  <= sram_dq_o_nxt;
         sram_dq_oe <= sram_dq_oe_nxt;
         sram_we_n  <= sram_we_n_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               state_nxt = LO;
               cnt_nxt   = '0;
            end
         end
         LO: begin
            if (phase_end) begin
               state_nxt = HI;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HI: begin
            if (phase_end) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rdata_nxt      = rdata;
      ready_nxt      = 1'b0;
      sram_addr_nxt  = sram_addr;
      sram_dq_o_nxt  = sram_dq_o;
      sram_dq_oe_nxt = 1'b0;
      sram_we_n_nxt  = 1'b1;

      case (state_nxt)
         LO: begin
            sram_addr_nxt = {eff_word, 1'b0};
            if (eff_wr) begin
               sram_dq_o_nxt  = eff_wdata[15:0];
               sram_dq_oe_nxt = 1'b1;
               sram_we_n_nxt  = 1'b0;
            end
         end
         HI: begin
            sram_addr_nxt = {eff_word, 1'b1};
            if (eff_wr) begin
               sram_dq_o_nxt  = eff_wdata[31:16];
               sram_dq_oe_nxt = 1'b1;
               sram_we_n_nxt  = 1'b0;
            end
         end
         DONE:    ready_nxt = 1'b1;
         default: ;
      endcase

      // Read data is sampled on the last edge of each phase.
      if (!op_wr && phase_end) begin
         if (state == LO) rdata_nxt[15:0]  = sram_dq_i;
         if (state == HI) rdata_nxt[31:16] = sram_dq_i;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural SRAM and a read-data scoreboard.
module tb_mem_access_ctrl;

   localparam int unsigned W = 2;

   logic        clk;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        freeze;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o;
   logic [15:0] sram_dq_i;
   logic        sram_dq_oe;
   logic        sram_we_n;

   mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
      .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: words 0/1 preset, anything written is remembered.
   logic [15:0] mem [0:63];
   logic [63:0] written = '0;
   logic [5:0]  ma;
   assign ma = sram_addr[5:0];
   assign sram_dq_i = written[ma] ? mem[ma] :
                      (ma == 6'd0) ? 16'hBEEF :
                      (ma == 6'd1) ? 16'hDEAD : 16'h0000;

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) begin
         mem[ma]     <= sram_dq_o;
         written[ma] <= 1'b1;
      end
   end

   int unsigned npass = 0;
   int unsigned ntot  = 0;
   logic [31:0] sb[$];
   logic [31:0] last_rd = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      chk("idle_ready", {31'b0, ready}, 32'd0);
      chk("idle_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("idle_oe", {31'b0, sram_dq_oe}, 32'd0);
      chk("idle_freeze", {31'b0, freeze}, 32'd0);
      chk("idle_rdata", rdata, last_rd);
   endtask

   // Called at a negedge while the DUT is in IDLE; returns at the ready-cycle negedge.
   task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd);
      logic [16:0] w;
      logic [31:0] got;
      w = 17'((a - 32'd1024) >> 2);
      if (!wr) last_rd = exp_rd;
      sb.push_back(last_rd);
      mem_w_en = wr;
      mem_r_en = rd;
      addr     = a;
      wdata    = d;
      for (int k = 1; k <= 2*W+1; k++) begin
         @(negedge clk);
         if (k <= 2*W) begin
            chk("freeze_busy", {31'b0, freeze}, 32'd1);
            chk("ready_busy", {31'b0, ready}, 32'd0);
            chk("sram_addr", {14'b0, sram_addr}, {14'b0, w, (k > W)});
            chk("we_n", {31'b0, sram_we_n}, {31'b0, ~wr});
            chk("oe", {31'b0, sram_dq_oe}, {31'b0, wr});
            if (wr) chk("dq_o", {16'b0, sram_dq_o}, {16'b0, (k > W) ? d[31:16] : d[15:0]});
         end else begin
            chk("ready_pulse", {31'b0, ready}, 32'd1);
            chk("freeze_rel", {31'b0, freeze}, 32'd0);
            if (sb.size() == 0) begin
               ntot++;
               $error("FAIL sb_empty: observed 0 entries expected 1");
            end else begin
               got = sb.pop_front();
               chk("rdata", rdata, got);
            end
         end
      end
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
      #1;
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_addr", {14'b0, sram_addr}, 32'd0);
      chk("rst_dq_o", {16'b0, sram_dq_o}, 32'd0);
      chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
      chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("rst_freeze0", {31'b0, freeze}, 32'd0);
      mem_r_en = 1'b1;
      #1 chk("rst_freeze1", {31'b0, freeze}, 32'd1);
      mem_r_en = 1'b0;
      @(negedge clk) rst = 1'b0;

      // plain read
      idle_cycle();
      access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF);
      idle_cycle();

      // plain write, rdata must hold
      access(1'b1, 1'b0, 32'd1028, 32'h12345678, 32'h0);
      idle_cycle();
      chk("mem2", {16'b0, mem[2]}, 32'h5678);
      chk("mem3", {16'b0, mem[3]}, 32'h1234);

      // both enables: write wins; low address bits ignored
      access(1'b1, 1'b1, 32'd1043, 32'hA5A55A5A, 32'h0);
      idle_cycle();
      chk("mem8", {16'b0, mem[8]}, 32'h5A5A);
      chk("mem9", {16'b0, mem[9]}, 32'hA5A5);

      // back-to-back read then write with one idle cycle between
      access(1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678);
      idle_cycle();
      access(1'b1, 1'b0, 32'd1048, 32'hCAFEF00D, 32'h0);
      idle_cycle();
      access(1'b0, 1'b1, 32'd1048, 32'h0, 32'hCAFEF00D);
      idle_cycle();

      // reset during HI of a write
      mem_w_en = 1'b1; addr = 32'd1056; wdata = 32'h0BADF00D;
      repeat (W + 1) @(negedge clk);
      chk("hi_we_n", {31'b0, sram_we_n}, 32'd0);
      chk("hi_addr", {14'b0, sram_addr}, 32'd17);
      #2 rst = 1'b1;
      #1;
      chk("abort_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("abort_oe", {31'b0, sram_dq_oe}, 32'd0);
      chk("abort_addr", {14'b0, sram_addr}, 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      chk("abort_freeze", {31'b0, freeze}, 32'd1);
      mem_w_en = 1'b0;
      #1 chk("abort_freeze0", {31'b0, freeze}, 32'd0);
      last_rd = 32'd0;
      @(negedge clk) rst = 1'b0;
      chk("no_partial", {31'b0, written[17]}, 32'd0);
      idle_cycle();
      access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF);
      idle_cycle();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
